fft_bfly_scheduler: RTL and testbench

FFT_BFLY_SCHEDULER -- requirements
Module: fft_bfly_scheduler

---
 rtl/fft_bfly_scheduler_pkg.sv | 21 ++
 rtl/fft_addr_gen.sv | 30 +++
 rtl/fft_bfly_scheduler.sv | 134 +++++++++++++
 tb/tb_fft_bfly_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bfly_scheduler_pkg.sv
// Shared FFT types: scheduler state encoding, default transform size and the complex sample type.
package fft_bfly_scheduler_pkg;

  localparam int unsigned FftNDefault     = 512;
  localparam int unsigned FftLog2NDefault = $clog2(FftNDefault);
  // Wide enough for the largest permitted in-flight limit (15).
  localparam int unsigned OutCntW         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } bfly_state_e;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT operand/twiddle address generator for butterfly j of a given stage.
module fft_addr_gen #(
  parameter int unsigned LOG2N = 9
) (
  input  logic [LOG2N-1:0] stage,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx
);

  localparam logic [LOG2N-1:0] TopStage = LOG2N[LOG2N-1:0] - 1'b1;

  logic [LOG2N-1:0] j_ext;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] tw_full;

  always_comb begin
    j_ext   = {1'b0, j};
    half    = {{(LOG2N-1){1'b0}}, 1'b1} << stage;
    pos     = j_ext & (half - 1'b1);
    // (j >> s) * 2 * half leaves bit s clear, so adding half is an OR.
    addr_a  = ((j_ext >> stage) << (stage + 1'b1)) | pos;
    addr_b  = addr_a | half;
    tw_full = pos << (TopStage - stage);
    tw_idx  = tw_full[LOG2N-2:0];
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Stage-by-stage butterfly issue sequencer with an in-flight limit and a per-stage write-back barrier.
module fft_bfly_scheduler
  import fft_bfly_scheduler_pkg::*;
#(
  parameter int unsigned N_POINTS        = FftNDefault,
  parameter int unsigned LOG2N           = $clog2(N_POINTS),
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bfly_valid,
  input  logic             bfly_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [LOG2N-1:0] stage,
  input  logic             wb_valid,
  output logic             err
);

  localparam int unsigned        JW        = LOG2N - 1;
  localparam logic [JW-1:0]      JLast     = JW'(N_POINTS / 2 - 1);
  localparam logic [LOG2N-1:0]   StageLast = LOG2N'(LOG2N - 1);
  localparam logic [OutCntW-1:0] MaxOut    = OutCntW'(MAX_OUTSTANDING);

  bfly_state_e        state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [LOG2N-1:0]   stage_q, stage_d;
  logic [OutCntW-1:0] out_q, out_d;
  logic               err_q, err_d;

  logic               issue_hs;
  logic [LOG2N-1:0]   gen_a, gen_b;
  logic [LOG2N-2:0]   gen_tw;

  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .stage  (stage_q),
    .j      (j_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      j_q     <= '0;
      stage_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // A write-back in the same cycle frees a slot, so the limit may be released combinationally.
    bfly_valid = (state_q == StIssue) && ((out_q < MaxOut) || wb_valid);
    issue_hs   = bfly_valid && bfly_ready;

    out_d = out_q;
    err_d = err_q;
    case ({issue_hs, wb_valid})
      2'b10: out_d = out_q + 1'b1;
      2'b01: begin
        if (out_q == '0) begin
          err_d = 1'b1;
        end else begin
          out_d = out_q - 1'b1;
        end
      end
      default: ;
    endcase

    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          j_d     = '0;
          stage_d = '0;
        end
      end
      StIssue: begin
        if (issue_hs) begin
          if (j_q == JLast) begin
            j_d     = '0;
            state_d = StDrain;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Barrier: leave only once the last write-back of this stage has landed.
        if (out_d == '0) begin
          if (stage_q == StageLast) begin
            state_d = StDone;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    stage  = stage_q;
    err    = err_q;
    addr_a = (state_q == StIssue) ? gen_a  : '0;
    addr_b = (state_q == StIssue) ? gen_b  : '0;
    tw_idx = (state_q == StIssue) ? gen_tw : '0;
  end

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench for an 8-point scheduler with an in-flight limit of 2.
module tb_fft_bfly_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       bfly_valid;
  logic       bfly_ready;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [1:0] tw_idx;
  logic [2:0] stage;
  logic       wb_valid;
  logic       err;

  logic       wb_auto = 1'b0;
  logic       wb_man  = 1'b0;
  logic [1:0] hist    = '0;
  int         n_issue = 0;
  int         errors  = 0;
  int         checks  = 0;
  logic [7:0] obs_pk;
  logic [7:0] tab [12];

  always #5 clk = ~clk;

  fft_bfly_scheduler #(
    .N_POINTS        (8),
    .LOG2N           (3),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bfly_valid (bfly_valid),
    .bfly_ready (bfly_ready),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .tw_idx     (tw_idx),
    .stage      (stage),
    .wb_valid   (wb_valid),
    .err        (err)
  );

  // Datapath model: write-back arrives two cycles after each accepted issue.
  always @(posedge clk) begin
    hist <= {hist[0], bfly_valid && bfly_ready};
    if (bfly_valid && bfly_ready) n_issue <= n_issue + 1;
  end
  assign wb_valid = wb_auto ? hist[1] : wb_man;
  assign obs_pk   = {addr_a, addr_b, tw_idx};

  function automatic logic [7:0] pk(input int a, input int b, input int t);
    pk = 8'((a << 5) | (b << 2) | t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(bfly_valid), 0);
    chk("rst_addr", 32'(obs_pk), 0);
    chk("rst_stage", 32'(stage), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  task automatic run_full(input bit rand_ready, input int budget, input string tag);
    int  k;
    int  snap;
    bit  seen_done;
    k = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    snap = n_issue;
    for (int c = 0; c < budget && !seen_done; c++) begin
      if (rand_ready) bfly_ready = 1'($urandom_range(0, 1));
      // A start while busy must not disturb the run.
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      #1;
      if (bfly_valid && k < 12) begin
        chk({tag, "_addr"}, 32'(obs_pk), 32'(tab[k]));
        if (bfly_ready) begin
          chk({tag, "_stage"}, 32'(stage), 32'(k / 4));
          k++;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_busy_in_done"}, 32'(busy), 1);
      end
      @(negedge clk);
    end
    bfly_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen_done), 1);
    chk({tag, "_issues_seen"}, 32'(k), 12);
    chk({tag, "_issue_count"}, 32'(n_issue - snap), 12);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int snap;
    tab = '{pk(0, 1, 0), pk(2, 3, 0), pk(4, 5, 0), pk(6, 7, 0),
            pk(0, 2, 0), pk(1, 3, 2), pk(4, 6, 0), pk(5, 7, 2),
            pk(0, 4, 0), pk(1, 5, 1), pk(2, 6, 2), pk(3, 7, 3)};
    rst        = 1'b1;
    start      = 1'b0;
    bfly_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();

    // Spurious write-back while idle sets the sticky error.
    @(negedge clk);
    rst    = 1'b0;
    wb_man = 1'b1;
    @(negedge clk);
    wb_man = 1'b0;
    #1;
    chk("spurious_err", 32'(err), 1);
    chk("spurious_busy", 32'(busy), 0);

    // Limit of 2: a counter left at 0 lets exactly two issues through.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    snap  = n_issue;
    #1;
    chk("lat_valid", 32'(bfly_valid), 1);
    chk("lat_addr0", 32'(obs_pk), 32'(pk(0, 1, 0)));
    chk("lat_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("lim_addr1", 32'(obs_pk), 32'(pk(2, 3, 0)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("lim_valid_low", 32'(bfly_valid), 0);
    end
    chk("lim_count2", 32'(n_issue - snap), 2);
    @(negedge clk);
    wb_man = 1'b1;
    #1;
    chk("lim_release", 32'(bfly_valid), 1);
    chk("lim_addr2", 32'(obs_pk), 32'(pk(4, 5, 0)));
    @(negedge clk);
    wb_man = 1'b0;
    #1;
    chk("lim_hold_low", 32'(bfly_valid), 0);
    chk("lim_count3", 32'(n_issue - snap), 3);

    // Stage barrier: last stage-0 write-back held back for 10 cycles.
    @(negedge clk);
    wb_man = 1'b1;
    #1;
    chk("bar_addr3", 32'(obs_pk), 32'(pk(6, 7, 0)));
    @(negedge clk);
    wb_man = 1'b0;
    #1;
    chk("bar_drain_valid", 32'(bfly_valid), 0);
    @(negedge clk);
    wb_man = 1'b1;
    @(negedge clk);
    wb_man = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bar_stage_hold", 32'(stage), 0);
      chk("bar_valid_hold", 32'(bfly_valid), 0);
      @(negedge clk);
    end
    wb_man = 1'b1;
    #1;
    chk("bar_stage_wbcyc", 32'(stage), 0);
    chk("bar_valid_wbcyc", 32'(bfly_valid), 0);
    @(negedge clk);
    wb_man = 1'b0;
    #1;
    chk("bar_stage1", 32'(stage), 1);
    chk("bar_valid1", 32'(bfly_valid), 1);
    chk("bar_addr_s1", 32'(obs_pk), 32'(pk(0, 2, 0)));
    chk("bar_count4", 32'(n_issue - snap), 4);
    @(negedge clk);
    #1;
    chk("bar_addr_s1j1", 32'(obs_pk), 32'(pk(1, 3, 2)));

    // Asynchronous reset in the middle of stage 1.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rerun_valid", 32'(bfly_valid), 1);
    chk("rerun_addr", 32'(obs_pk), 32'(pk(0, 1, 0)));
    chk("rerun_stage", 32'(stage), 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    wb_auto = 1'b1;

    run_full(1'b0, 100, "seq");
    run_full(1'b1, 400, "bp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
